inst_loader: RTL

Boot-time writer for the instruction ROM. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word into consecutive ROM word addresses starting at 0, and holds the core in reset-equivalent stall until the image is complete. It is the write-side counterpart of the fetch path that reads the ROM by `addr[31:2]`.

---
 rtl/inst_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Boot-time writer for the instruction ROM. A byte stream arrives over a
// valid/ready handshake and is packed little-endian into 32-bit instruction
// words. Each word is written to the next ROM word address, starting at 0.
// While a load is running, busy is held high so the core stays stalled and
// the fetch path substitutes NOPs. The fetch side reads the same ROM by
// addr[31:2], so waddr here is a word index, not a byte address.
//
// Parameters
//   DEPTH       ROM depth in 32-bit words
//   AW          word-address width, log2(DEPTH)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       one-cycle load request, honoured only in IDLE
//   len         number of words to load, sampled with start
//   abort       cancel an in-progress load (RECV or WRITE only)
//   byte_valid  source presents a byte on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   we          ROM write strobe, one cycle per word
//   waddr       ROM word address
//   wdata       ROM write data
//   busy        load in progress (core stall / fetch flush)
//   done        one-cycle pulse once all len words are written
//   err         one-cycle pulse on rejected start or on abort
//   csum        XOR of every word written since the last accepted start
//
// All outputs come straight from flops. Because of that, the write of a word
// is committed on the same edge that accepts its fourth byte: we, waddr,
// wdata and csum all change together and are seen in the WRITE cycle.
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   csum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] WCNT_ONE = (AW + 1)'(1);

    state_t       state;
    logic [AW:0]  len_q;   // words requested for the current load
    logic [AW:0]  wcnt;    // words written so far; one bit wider so it can equal DEPTH
    logic [1:0]   bcnt;    // bytes of the current word already accepted
    logic [23:0]  asm_q;   // bytes 0..2 of the word being assembled
    logic         hs;
    logic [31:0]  word_full;

    // byte_ready is a flop, so the handshake is fully registered-side.
    assign hs        = byte_valid & byte_ready;

    // The fourth byte goes straight into the top lane of the written word
    // rather than through asm_q, which saves a cycle per word.
    assign word_full = {byte_data, asm_q};

    // Assembly lanes for bytes 0..2. Pure data, no reset needed: a partial
    // word is discarded simply by clearing bcnt, and stale lanes are always
    // overwritten before they are used.
    always_ff @(posedge clk) begin
        if (state == RECV && hs && !abort) begin
            case (bcnt)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                2'd2:    asm_q[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            csum       <= '0;
        end else begin
            // Strobes default low; each is raised only for the single cycle
            // that follows the edge that sets it.
            we   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            // Empty image: straight to DONE, nothing written,
                            // and the checksum of zero words is zero.
                            csum  <= '0;
                            state <= DONE;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else if (len > DEPTH_L) begin
                            // Image would not fit: reject, keep old csum.
                            err <= 1'b1;
                        end else begin
                            len_q      <= len;
                            wcnt       <= '0;
                            bcnt       <= '0;
                            csum       <= '0;
                            state      <= RECV;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        bcnt       <= '0;
                        err        <= 1'b1;
                    end else if (hs) begin
                        if (bcnt == 2'd3) begin
                            // Word complete: commit it now so the strobe,
                            // address, data and checksum are all visible in
                            // the WRITE cycle.
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            we         <= 1'b1;
                            waddr      <= wcnt[AW-1:0];
                            wdata      <= word_full;
                            csum       <= csum ^ word_full;
                            wcnt       <= wcnt + WCNT_ONE;
                            bcnt       <= '0;
                        end else begin
                            bcnt <= bcnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (wcnt == len_q) begin
                        // wcnt already counts the word just written.
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
